ha_frame_accumulator: RTL

Downstream consumer of the pipelined half-adder stage. Each accepted cycle, it takes the registered `S`/`cout` pair as a 2-bit value (`{cout,S}`) and accumulates it over a frame of `FRAME_LEN` samples. At the end of each frame it presents the total on a valid/ready output register. A single-entry output buffer plus input backpressure let the frame total wait for a slow consumer without losing samples.

---
 rtl/ha_frame_accumulator.sv | 107 ++++++++++
 1 files changed

// File: rtl/ha_frame_accumulator.sv
// ha_frame_accumulator: sums {cout,S} samples over FRAME_LEN accepted cycles and
// presents each frame total on a single-entry valid/ready output register.
`default_nettype none

module ha_frame_accumulator #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             S,
   input  logic             cout,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             overflow
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [WIDTH-1:0]   sum_out_q, sum_out_d;
   logic               overflow_q, overflow_d;
   logic               sum_valid_q, sum_valid_d;
   logic [WIDTH-1:0]   sample;
   logic [WIDTH:0]     acc_sum;
   logic               accept;
   logic               frame_end;

   // The mode is fully determined by the current cycle's conditions, so the
   // last sample of a frame is held off only while an unconsumed result blocks it.
   always_comb begin
      state = ACCUM;
      if (cnt_q == LAST_CNT && sum_valid_q && !sum_ready) begin
         state = STALL;
      end
   end

   assign in_ready  = (state == ACCUM);
   assign accept    = in_valid && in_ready;
   assign frame_end = accept && (cnt_q == LAST_CNT);
   assign sample    = WIDTH'({cout, S});
   assign acc_sum   = {1'b0, acc_q} + {1'b0, sample};

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_acc_d   = ovf_acc_q;
      sum_out_d   = sum_out_q;
      overflow_d  = overflow_q;
      sum_valid_d = sum_valid_q;

      if (sum_valid_q && sum_ready) begin
         sum_valid_d = 1'b0;
      end

      if (frame_end) begin
         // A frame end on the same edge as a consume reloads the output register.
         sum_out_d   = acc_sum[WIDTH-1:0];
         overflow_d  = ovf_acc_q | acc_sum[WIDTH];
         sum_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
         ovf_acc_d   = 1'b0;
      end else if (accept) begin
         acc_d     = acc_sum[WIDTH-1:0];
         ovf_acc_d = ovf_acc_q | acc_sum[WIDTH];
         cnt_d     = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_acc_q   <= 1'b0;
         sum_out_q   <= '0;
         overflow_q  <= 1'b0;
         sum_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_acc_q   <= ovf_acc_d;
         sum_out_q   <= sum_out_d;
         overflow_q  <= overflow_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign sum_out   = sum_out_q;
   assign overflow  = overflow_q;
   assign sum_valid = sum_valid_q;

endmodule

`default_nettype wire
